// File: rtl/alu_ret_pkg.sv
// rtl/alu_ret_pkg.sv - shared entry type, widths and helpers for the ALU result collector
package alu_ret_pkg;

    localparam int RET_W = 9;
    localparam int N_ALU = 6;
    localparam int TAG_W = 9;

    typedef struct packed {
        logic [RET_W-1:0] ret;
        logic [TAG_W-1:0] tag;
    } ret_ent_t;

    function automatic int clog2_pow2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == n) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_ret_prefix.sv
// rtl/alu_ret_prefix.sv - valid vector to per-port compaction offsets plus total count
module alu_ret_prefix #(
    parameter int N  = 6,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         vld,
    output logic [N-1:0][CW-1:0] off,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    always_comb begin
        acc = '0;
        off = '0;
        for (int k = 0; k < N; k++) begin
            off[k] = acc;
            acc    = acc + CW'(vld[k]);
        end
        total = acc;
    end

endmodule

// File: rtl/alu_ret_collect.sv
// rtl/alu_ret_collect.sv - compacts ALU result-flag writes into a circular buffer for retire
// Optional high-water-mark output enabled by defining ALU_RET_HWM_EN.
module alu_ret_collect
    import alu_ret_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int N_IN  = N_ALU,
    parameter int N_OUT = 3,
    parameter int TAG_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     except,
    input  logic [N_IN-1:0]          in_vld,
    input  logic [N_IN*RET_W-1:0]    in_ret,
    input  logic [N_IN*TAG_W-1:0]    in_tag,
    output logic [N_OUT-1:0]         out_vld,
    output logic [N_OUT*RET_W-1:0]   out_ret,
    output logic [N_OUT*TAG_W-1:0]   out_tag,
    input  logic                     out_rdy,
    output logic                     stall,
    output logic                     ovf
`ifdef ALU_RET_HWM_EN
    , output logic [clog2_pow2(DEPTH):0] hwm
`endif
);

    localparam int AW = clog2_pow2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(N_IN + 1);
    // Two cycles of in-flight ALU ops must still fit after stall is raised.
    localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 2 * N_IN);

    logic [AW-1:0]           head, tail;
    logic [CW-1:0]           count, count_next;
    logic [CW-1:0]           free, nin_w, nacc, ndeq;
    logic                    drop;
    logic [N_IN-1:0][NW-1:0] off;
    logic [NW-1:0]           nin;
    logic [N_IN-1:0]         acc_mask;
    ret_ent_t                mem [DEPTH];

    alu_ret_prefix #(.N(N_IN), .CW(NW)) u_prefix (
        .vld   (in_vld),
        .off   (off),
        .total (nin)
    );

    // Space is judged against the pre-dequeue count; excess ports above `free` are dropped.
    always_comb begin
        nin_w = CW'(nin);
        free  = CW'(DEPTH) - count;
        drop  = nin_w > free;
        nacc  = drop ? free : nin_w;
        ndeq  = '0;
        if (out_rdy) begin
            ndeq = (count > CW'(N_OUT)) ? CW'(N_OUT) : count;
        end
        for (int k = 0; k < N_IN; k++) begin
            acc_mask[k] = in_vld[k] && (CW'(off[k]) < free);
        end
        count_next = except ? '0 : (count + nacc - ndeq);
    end

    always_ff @(posedge clk) begin
        if (!except) begin
            for (int k = 0; k < N_IN; k++) begin
                if (acc_mask[k]) begin
                    mem[tail + AW'(off[k])] <= ret_ent_t'{
                        ret: in_ret[k*RET_W +: RET_W],
                        tag: in_tag[k*TAG_W +: TAG_W]
                    };
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            stall <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            stall <= count_next > STALL_TH;
            if (except) begin
                head <= '0;
                tail <= '0;
            end else begin
                head <= head + AW'(ndeq);
                tail <= tail + AW'(nacc);
                ovf  <= ovf | drop;
            end
        end
    end

`ifdef ALU_RET_HWM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm <= '0;
        end else if (count_next > hwm) begin
            hwm <= count_next;
        end
    end
`endif

    always_comb begin
        out_vld = '0;
        out_ret = '0;
        out_tag = '0;
        for (int j = 0; j < N_OUT; j++) begin
            out_vld[j]                 = count > CW'(j);
            out_ret[j*RET_W +: RET_W]  = mem[head + AW'(j)].ret;
            out_tag[j*TAG_W +: TAG_W]  = mem[head + AW'(j)].tag;
        end
    end

endmodule

// File: tb/tb_alu_ret_collect.sv
// tb/tb_alu_ret_collect.sv - scoreboard bench for alu_ret_collect against a queue model
`timescale 1ns/1ps
module tb_alu_ret_collect;

    localparam int DEPTH = 16;
    localparam int N_IN  = 6;
    localparam int N_OUT = 3;
    localparam int TAG_W = 9;
    localparam int RET_W = 9;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   except = 1'b0;
    logic                   out_rdy = 1'b0;
    logic [N_IN-1:0]        in_vld = '0;
    logic [N_IN*RET_W-1:0]  in_ret = '0;
    logic [N_IN*TAG_W-1:0]  in_tag = '0;
    logic [N_OUT-1:0]       out_vld;
    logic [N_OUT*RET_W-1:0] out_ret;
    logic [N_OUT*TAG_W-1:0] out_tag;
    logic                   stall;
    logic                   ovf;
`ifdef ALU_RET_HWM_EN
    logic [4:0]             hwm;
`endif

    alu_ret_collect #(.DEPTH(DEPTH), .N_IN(N_IN), .N_OUT(N_OUT), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .except  (except),
        .in_vld  (in_vld),
        .in_ret  (in_ret),
        .in_tag  (in_tag),
        .out_vld (out_vld),
        .out_ret (out_ret),
        .out_tag (out_tag),
        .out_rdy (out_rdy),
        .stall   (stall),
        .ovf     (ovf)
`ifdef ALU_RET_HWM_EN
        , .hwm   (hwm)
`endif
    );

    always #5 clk = ~clk;

    // Every accepted entry in arrival order, {ret, tag}; front is the oldest live entry.
    logic [RET_W+TAG_W-1:0] exp_q[$];
    int  pushed_now = 0;
    bit  drop_now   = 1'b0;
    bit  exp_stall  = 1'b0;
    bit  exp_ovf    = 1'b0;
    int  exp_hwm    = 0;
    int  n_chk      = 0;
    int  n_pass     = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(input logic [N_IN-1:0] v, input bit rdy, input bit exc, input bit seq_tags);
        int vis;
        int acc;
        int nt;
        vis      = exp_q.size();
        acc      = 0;
        nt       = 1;
        drop_now = 1'b0;
        in_vld   = v;
        out_rdy  = rdy;
        except   = exc;
        for (int k = 0; k < N_IN; k++) begin
            in_ret[k*RET_W +: RET_W] = RET_W'($urandom);
            in_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom);
            if (seq_tags && v[k]) begin
                in_tag[k*TAG_W +: TAG_W] = TAG_W'(nt);
                nt++;
            end
            if (v[k] && !exc) begin
                if (acc < DEPTH - vis) begin
                    exp_q.push_back({in_ret[k*RET_W +: RET_W], in_tag[k*TAG_W +: TAG_W]});
                    acc++;
                end else begin
                    drop_now = 1'b1;
                end
            end
        end
        pushed_now = acc;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        int vis;
        int nv;
        int cnext;
        if (!rst) begin
            chk("rst_out_vld", out_vld, 0);
            chk("rst_stall", stall, 0);
            chk("rst_ovf", ovf, 0);
            exp_q.delete();
            exp_stall = 1'b0;
            exp_ovf   = 1'b0;
            exp_hwm   = 0;
        end else begin
            vis = exp_q.size() - pushed_now;
            nv  = (vis > N_OUT) ? N_OUT : vis;
            chk("out_vld", out_vld, (1 << nv) - 1);
            chk("stall", stall, exp_stall);
            chk("ovf", ovf, exp_ovf);
`ifdef ALU_RET_HWM_EN
            chk("hwm", hwm, exp_hwm);
`endif
            for (int j = 0; j < nv; j++) begin
                chk("slot_ret", out_ret[j*RET_W +: RET_W], exp_q[j][RET_W+TAG_W-1:TAG_W]);
                chk("slot_tag", out_tag[j*TAG_W +: TAG_W], exp_q[j][TAG_W-1:0]);
            end
            if (except) begin
                exp_q.delete();
                cnext = 0;
            end else begin
                if (out_rdy) repeat (nv) void'(exp_q.pop_front());
                cnext   = exp_q.size();
                exp_ovf = exp_ovf | drop_now;
            end
            exp_stall = cnext > (DEPTH - 2 * N_IN);
            if (cnext > exp_hwm) exp_hwm = cnext;
        end
    end

    initial begin
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        cycle(6'b101001, 1'b0, 1'b0, 1'b1);
        cycle(6'b000000, 1'b0, 1'b0, 1'b0);
        cycle(6'b000000, 1'b0, 1'b1, 1'b0);
        cycle(6'b000000, 1'b0, 1'b0, 1'b0);

        repeat (3) cycle(6'h3F, 1'b0, 1'b0, 1'b0);
        cycle(6'b000000, 1'b0, 1'b0, 1'b0);

        repeat (4) cycle(6'b000000, 1'b1, 1'b0, 1'b0);
        cycle(6'b000001, 1'b0, 1'b0, 1'b0);
        cycle(6'h3F, 1'b1, 1'b1, 1'b0);
        cycle(6'b000000, 1'b0, 1'b0, 1'b0);

        repeat (400) begin
            cycle(N_IN'($urandom) & N_IN'($urandom | $urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 49) == 0), 1'b0);
        end

        cycle(6'b000000, 1'b0, 1'b1, 1'b0);
        cycle(6'h3F, 1'b0, 1'b0, 1'b0);
        cycle(6'b000111, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_out_vld", out_vld, 7);
        chk("pre_rst_ovf", ovf, exp_ovf);
        rst = 1'b0;
        #1;
        chk("async_rst_out_vld", out_vld, 0);
        chk("async_rst_stall", stall, 0);
        chk("async_rst_ovf", ovf, 0);
        @(negedge clk);
        #2;
        in_vld     = '0;
        out_rdy    = 1'b0;
        except     = 1'b0;
        pushed_now = 0;
        drop_now   = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;

        repeat (200) begin
            cycle(N_IN'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0), 1'b0);
        end
        repeat (8) cycle(6'b000000, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
